prio_grant_arbiter: RTL and testbench

Fixed-priority arbiter with grant hold that shares one resource among 4 requesters; req[3] has the highest priority and req[0] the lowest.
- A granted requester keeps the resource while it holds its request, up to a MAX_HOLD-cycle limit.
- On timeout, the owner is masked for one arbitration round so lower-priority requesters are not starved.
- Sits between the requesting masters and the shared datapath; gnt_id drives the datapath select mux.

---
 rtl/prio_arb_pkg.sv | 23 ++
 rtl/prio_pick4.sv | 25 ++
 rtl/prio_grant_arbiter.sv | 109 ++++++++++
 tb/tb_prio_grant_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared definitions for the fixed-priority grant arbiter.
//   state_e : arbiter FSM states (IDLE, GRANT)
//   N_REQ   : number of requesters (fixed at 4)
//   ID_W    : width of an encoded requester index
//   onehot  : converts an encoded index into a one-hot requester vector
package prio_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational 4-input priority picker; bit 3 has the highest priority.
//   vec_i   : candidate vector
//   id_o    : index of the highest set bit (0 when vec_i is zero)
//   valid_o : high when any bit of vec_i is set
module prio_pick4
    import prio_arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [ID_W-1:0]  id_o,
    output logic             valid_o
);

    always_comb begin
        id_o    = '0;
        valid_o = 1'b1;
        casez (vec_i)
            4'b1???: id_o = 2'd3;
            4'b01??: id_o = 2'd2;
            4'b001?: id_o = 2'd1;
            4'b0001: id_o = 2'd0;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/prio_grant_arbiter.sv
// Fixed-priority arbiter with grant hold for 4 requesters (req[3] highest).
// An owner keeps the grant while it keeps requesting, for at most MAX_HOLD
// cycles; on timeout the owner is masked for the next arbitration so that
// lower-priority requesters get a turn. Every release or timeout is followed
// by exactly one IDLE cycle with gnt low.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   req       : request lines
//   gnt       : registered one-hot grant (zero when no owner)
//   gnt_id    : encoded owner index, meaningful while gnt_valid is high
//   gnt_valid : |gnt
//   timeout   : one-cycle pulse when a grant is revoked by the hold limit
//   dbg_state : current FSM state, for observation only
//
// Handshake: a requester holds req high for as long as it wants the resource;
// it owns the resource in every cycle in which its gnt bit is high and
// releases it by dropping req. There is no preemption of a current owner.
module prio_grant_arbiter
    import prio_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout,
    output state_e           dbg_state
);

    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [ID_W-1:0]  gnt_id_q;
    logic             timeout_q;
    logic [HC_W-1:0]  hold_q;
    logic [HC_W-1:0]  hold_d;
    logic [N_REQ-1:0] mask_q;

    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] eligible;
    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;
    logic             owner_req;
    logic             hold_expired;

    // A masked requester only loses if someone else is asking; when it is
    // the sole requester the mask is ignored so the resource is not left idle.
    assign masked_req = req & ~mask_q;
    assign eligible   = (masked_req != '0) ? masked_req : req;

    prio_pick4 u_pick (
        .vec_i   (eligible),
        .id_o    (pick_id),
        .valid_o (pick_valid)
    );

    assign owner_req    = req[gnt_id_q];
    assign hold_d       = hold_q + HC_W'(1);
    assign hold_expired = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            mask_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q    <= onehot(pick_id);
                        gnt_id_q <= pick_id;
                        hold_q   <= '0;
                        mask_q   <= '0;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (hold_expired) begin
                        gnt_q     <= '0;
                        timeout_q <= 1'b1;
                        mask_q    <= onehot(gnt_id_q);
                        state_q   <= IDLE;
                    end else begin
                        hold_q <= hold_d;
                    end
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prio_grant_arbiter.sv
// Bench for prio_grant_arbiter with MAX_HOLD=4: directed scenarios followed by
// randomized request traffic checked against a behavioural model.
module tb_prio_grant_arbiter;
    import prio_arb_pkg::*;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    state_e     dbg_state;

    int n_checks;
    int n_errors;

    // behavioural model: owner index (-1 none), cycles shown granted,
    // masked requester index (-1 none), timeout pulse
    int m_owner;
    int m_held;
    int m_masked;
    int m_pulse;

    logic [5:0] exp_q[$];
    logic [1:0] exp_id_q[$];

    prio_grant_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one edge per table row; row = {rst_n, req[3:0]} / {exp gnt, exp timeout}
    task automatic test_reset();
        logic [4:0] in_t [0:4];
        logic [4:0] ex_t [0:4];
        logic [3:0] eg;
        logic [1:0] eid;
        in_t = '{5'b0_1111, 5'b0_1111, 5'b1_1111, 5'b1_0000, 5'b1_0000};
        ex_t = '{5'b0000_0, 5'b0000_0, 5'b1000_0, 5'b0000_0, 5'b0000_0};
        for (int i = 0; i < 5; i++) begin
            rst_n = in_t[i][4];
            req   = in_t[i][3:0];
            tick();
            eg = ex_t[i][4:1];
            n_checks++;
            if ({gnt, gnt_valid, timeout} !== {eg, eg != 4'b0, ex_t[i][0]}) begin
                n_errors++;
                $display("FAIL reset step %0d: gnt=%b valid=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, gnt_valid, timeout, eg, ex_t[i][0]);
            end
            if (i < 2) begin
                n_checks++;
                if (gnt_id !== 2'd0) begin
                    n_errors++;
                    $display("FAIL reset gnt_id step %0d: got %0d, expected 0", i, gnt_id);
                end
            end
            if (eg != 4'b0) begin
                eid = '0;
                for (int b = 0; b < 4; b++) if (eg[b]) eid = 2'(b);
                n_checks++;
                if (gnt_id !== eid) begin
                    n_errors++;
                    $display("FAIL reset gnt_id step %0d: got %0d, expected %0d", i, gnt_id, eid);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] in_t [0:5];
        logic [4:0] ex_t [0:5];
        logic [3:0] eg;
        logic [1:0] eid;
        in_t = '{4'b0110, 4'b0110, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        ex_t = '{5'b0100_0, 5'b0100_0, 5'b0000_0, 5'b0010_0, 5'b0000_0, 5'b0000_0};
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req = in_t[i];
            tick();
            eg = ex_t[i][4:1];
            n_checks++;
            if ({gnt, gnt_valid, timeout} !== {eg, eg != 4'b0, ex_t[i][0]}) begin
                n_errors++;
                $display("FAIL priority step %0d: gnt=%b valid=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, gnt_valid, timeout, eg, ex_t[i][0]);
            end
            if (eg != 4'b0) begin
                eid = '0;
                for (int b = 0; b < 4; b++) if (eg[b]) eid = 2'(b);
                n_checks++;
                if (gnt_id !== eid) begin
                    n_errors++;
                    $display("FAIL priority gnt_id step %0d: got %0d, expected %0d", i, gnt_id, eid);
                end
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [3:0] in_t [0:6];
        logic [4:0] ex_t [0:6];
        logic [3:0] eg;
        logic [1:0] eid;
        in_t = '{4'b0001, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        ex_t = '{5'b0001_0, 5'b0001_0, 5'b0001_0, 5'b0000_0, 5'b1000_0, 5'b0000_0, 5'b0000_0};
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req = in_t[i];
            tick();
            eg = ex_t[i][4:1];
            n_checks++;
            if ({gnt, gnt_valid, timeout} !== {eg, eg != 4'b0, ex_t[i][0]}) begin
                n_errors++;
                $display("FAIL no_preempt step %0d: gnt=%b valid=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, gnt_valid, timeout, eg, ex_t[i][0]);
            end
            if (eg != 4'b0) begin
                eid = '0;
                for (int b = 0; b < 4; b++) if (eg[b]) eid = 2'(b);
                n_checks++;
                if (gnt_id !== eid) begin
                    n_errors++;
                    $display("FAIL no_preempt gnt_id step %0d: got %0d, expected %0d", i, gnt_id, eid);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] in_t [0:12];
        logic [4:0] ex_t [0:12];
        logic [3:0] eg;
        logic [1:0] eid;
        in_t = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
        ex_t = '{5'b1000_0, 5'b1000_0, 5'b1000_0, 5'b1000_0, 5'b0000_1,
                 5'b0001_0, 5'b0001_0, 5'b0001_0, 5'b0001_0, 5'b0000_1,
                 5'b1000_0, 5'b0000_0, 5'b0000_0};
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            req = in_t[i];
            tick();
            eg = ex_t[i][4:1];
            n_checks++;
            if ({gnt, gnt_valid, timeout} !== {eg, eg != 4'b0, ex_t[i][0]}) begin
                n_errors++;
                $display("FAIL timeout step %0d: gnt=%b valid=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, gnt_valid, timeout, eg, ex_t[i][0]);
            end
            if (eg != 4'b0) begin
                eid = '0;
                for (int b = 0; b < 4; b++) if (eg[b]) eid = 2'(b);
                n_checks++;
                if (gnt_id !== eid) begin
                    n_errors++;
                    $display("FAIL timeout gnt_id step %0d: got %0d, expected %0d", i, gnt_id, eid);
                end
            end
        end
    endtask

    // Lone masked requester: 5-cycle period of 4 grants + timeout cycle.
    // Leaves the arbiter idle with req[3] masked.
    task automatic test_lone_masked();
        logic [3:0] eg;
        logic       et;
        rst_n = 1'b1;
        req   = 4'b1000;
        for (int i = 0; i < 15; i++) begin
            tick();
            et = ((i % 5) == 4);
            eg = et ? 4'b0000 : 4'b1000;
            n_checks++;
            if ({gnt, gnt_valid, timeout} !== {eg, !et, et}) begin
                n_errors++;
                $display("FAIL lone_masked cycle %0d: gnt=%b valid=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, gnt_valid, timeout, eg, et);
            end
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if ({gnt, timeout} !== 5'b0000_0) begin
            n_errors++;
            $display("FAIL lone_masked idle: gnt=%b timeout=%b, expected 0000/0", gnt, timeout);
        end
    endtask

    task automatic test_mid_reset();
        // grant to req[1], reset during its second cycle
        rst_n = 1'b1;
        req   = 4'b0010;
        tick();
        tick();
        n_checks++;
        if ({gnt, gnt_id} !== {4'b0010, 2'd1}) begin
            n_errors++;
            $display("FAIL mid_reset pre: gnt=%b id=%0d, expected 0010/1", gnt, gnt_id);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({gnt, gnt_valid, timeout, gnt_id} !== 8'b0) begin
            n_errors++;
            $display("FAIL mid_reset during: gnt=%b valid=%b timeout=%b id=%0d, expected all 0",
                     gnt, gnt_valid, timeout, gnt_id);
        end
        rst_n = 1'b1;
        req   = 4'b1010;
        tick();
        n_checks++;
        if ({gnt, gnt_id} !== {4'b1000, 2'd3}) begin
            n_errors++;
            $display("FAIL mid_reset after: gnt=%b id=%0d, expected 1000/3", gnt, gnt_id);
        end
        req = 4'b0000;
        tick();
        tick();
        // time req[3] out so it is masked, then reset while idle: mask must clear
        req = 4'b1000;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if ({gnt, timeout} !== 5'b0000_1) begin
            n_errors++;
            $display("FAIL mid_reset mask setup: gnt=%b timeout=%b, expected 0000/1", gnt, timeout);
        end
        req   = 4'b0000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1010;
        tick();
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_errors++;
            $display("FAIL mid_reset mask cleared: gnt=%b, expected 1000", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // model: one clock edge with the given inputs
    task automatic model_step(input logic rst_l, input logic [3:0] r);
        int best;
        if (!rst_l) begin
            m_owner  = -1;
            m_held   = 0;
            m_masked = -1;
            m_pulse  = 0;
        end else if (m_owner < 0) begin
            m_pulse = 0;
            best    = -1;
            for (int i = 0; i < 4; i++) if (r[i] && i != m_masked) best = i;
            if (best < 0) for (int i = 0; i < 4; i++) if (r[i]) best = i;
            if (best >= 0) begin
                m_owner  = best;
                m_held   = 1;
                m_masked = -1;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (MAXH > 0 && m_held == MAXH) begin
            m_masked = m_owner;
            m_owner  = -1;
            m_pulse  = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic test_random();
        logic [5:0] e;
        logic [1:0] eid;
        logic [3:0] eg;
        rst_n = 1'b0;
        req   = 4'b0000;
        model_step(1'b0, req);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 79) != 0);
            model_step(rst_n, req);
            eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            exp_q.push_back({eg, eg != 4'b0, m_pulse[0]});
            exp_id_q.push_back((m_owner < 0) ? 2'd0 : 2'(m_owner));
            tick();
            e   = exp_q.pop_front();
            eid = exp_id_q.pop_front();
            n_checks++;
            if ({gnt, gnt_valid, timeout} !== e) begin
                n_errors++;
                $display("FAIL random cycle %0d: gnt=%b valid=%b timeout=%b, expected gnt=%b valid=%b timeout=%b",
                         c, gnt, gnt_valid, timeout, e[5:2], e[1], e[0]);
            end
            if (e[1]) begin
                n_checks++;
                if (gnt_id !== eid) begin
                    n_errors++;
                    $display("FAIL random gnt_id cycle %0d: got %0d, expected %0d", c, gnt_id, eid);
                end
            end
            n_checks++;
            if ($countones(gnt) > 1 || (timeout && gnt != 4'b0)) begin
                n_errors++;
                $display("FAIL random invariant cycle %0d: gnt=%b timeout=%b, expected zero/one-hot gnt and no timeout with gnt",
                         c, gnt, timeout);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_owner  = -1;
        m_held   = 0;
        m_masked = -1;
        m_pulse  = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        test_reset();
        test_priority();
        test_no_preempt();
        test_timeout();
        test_lone_masked();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
